// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csr_pkg
//  Description : Shared definitions for the machine-mode CSR unit: widths,
//                CSR address map, operation encoding and write masks.
//  Revision    : 1.0 - initial release
// ============================================================================
package csr_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int CSR_WIDTH  = 64;

    // Machine-mode registers
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    // User read-only shadows of the machine counters
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    typedef enum logic [1:0] {
        CSR_NOP = 2'd0,
        CSR_RW  = 2'd1,
        CSR_RS  = 2'd2,
        CSR_RC  = 2'd3
    } csr_op_e;

    // mtvec is direct-mode only and mepc is word aligned: low two bits read 0
    localparam logic [DATA_WIDTH-1:0] MTVEC_WMASK = 32'hFFFF_FFFC;
    localparam logic [DATA_WIDTH-1:0] MEPC_WMASK  = 32'hFFFF_FFFC;

endpackage
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// ============================================================================
//  Module      : csr_counter64
//  Description : 64-bit free-running counter with increment enable and a
//                32-bit write port per half. A write to either half replaces
//                that half, holds the other and suppresses the increment.
//  Ports       : clk_i, rst_i (async, active high), inc_i, we_lo_i, we_hi_i,
//                wdata_i[DATA_WIDTH-1:0], count_o[CSR_WIDTH-1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_counter64
    import csr_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  inc_i,
    input  logic                  we_lo_i,
    input  logic                  we_hi_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [CSR_WIDTH-1:0]  count_o
);

    logic [CSR_WIDTH-1:0] count_q;
    logic [CSR_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (we_lo_i || we_hi_i) begin
            if (we_lo_i) count_d[DATA_WIDTH-1:0]         = wdata_i;
            if (we_hi_i) count_d[CSR_WIDTH-1:DATA_WIDTH] = wdata_i;
        end else if (inc_i) begin
            count_d = count_q + {{(CSR_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/csr_rw_unit.sv
`default_nettype none
// ============================================================================
//  Module      : csr_rw_unit
//  Description : Machine-mode CSR read/modify/write unit. Executes CSRRW/S/C
//                from EX, owns mcycle/minstret (plus user read-only aliases),
//                mscratch, mepc and mtvec. Returns the pre-write CSR value
//                and flags illegal accesses.
//  Ports       : clk_i, rst_i (async, active high)
//                csr_valid_i, flush_ID_EX_i, csr_op_i[1:0], csr_addr_i[11:0],
//                csr_src_i[DATA_WIDTH-1:0], src_is_x0_i, retire_i
//                csr_rdata_o[DATA_WIDTH-1:0] (comb), illegal_o (comb)
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_rw_unit
    import csr_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  csr_valid_i,
    input  logic                  flush_ID_EX_i,
    input  logic [1:0]            csr_op_i,
    input  logic [11:0]           csr_addr_i,
    input  logic [DATA_WIDTH-1:0] csr_src_i,
    input  logic                  src_is_x0_i,
    input  logic                  retire_i,
    output logic [DATA_WIDTH-1:0] csr_rdata_o,
    output logic                  illegal_o
);

    logic [DATA_WIDTH-1:0] mtvec_q,    mtvec_d;
    logic [DATA_WIDTH-1:0] mscratch_q, mscratch_d;
    logic [DATA_WIDTH-1:0] mepc_q,     mepc_d;
    logic [CSR_WIDTH-1:0]  mcycle;
    logic [CSR_WIDTH-1:0]  minstret;

    csr_op_e               op;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  mapped;
    logic                  active;
    logic                  write_req;
    logic                  illegal;
    logic                  we;

    assign op = csr_op_e'(csr_op_i);

    // Read mux; the user counter addresses alias the machine counter halves
    always_comb begin
        rdata  = '0;
        mapped = 1'b1;
        case (csr_addr_i)
            CSR_MTVEC:                   rdata = mtvec_q;
            CSR_MSCRATCH:                rdata = mscratch_q;
            CSR_MEPC:                    rdata = mepc_q;
            CSR_MCYCLE,   CSR_CYCLE:     rdata = mcycle[DATA_WIDTH-1:0];
            CSR_MCYCLEH,  CSR_CYCLEH:    rdata = mcycle[CSR_WIDTH-1:DATA_WIDTH];
            CSR_MINSTRET, CSR_INSTRET:   rdata = minstret[DATA_WIDTH-1:0];
            CSR_MINSTRETH, CSR_INSTRETH: rdata = minstret[CSR_WIDTH-1:DATA_WIDTH];
            default:                     mapped = 1'b0;
        endcase
    end

    // RS/RC with a zero source are pure reads, so they may target read-only CSRs
    always_comb begin
        active    = csr_valid_i & ~flush_ID_EX_i & (op != CSR_NOP);
        write_req = active & ((op == CSR_RW) | ~src_is_x0_i);
        illegal   = active & (~mapped | ((csr_addr_i[11:10] == 2'b11) & write_req));
        we        = write_req & ~illegal;
    end

    always_comb begin
        case (op)
            CSR_RW:  wdata = csr_src_i;
            CSR_RS:  wdata = rdata | csr_src_i;
            CSR_RC:  wdata = rdata & ~csr_src_i;
            default: wdata = rdata;
        endcase
    end

    always_comb begin
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        if (we) begin
            case (csr_addr_i)
                CSR_MTVEC:    mtvec_d    = wdata & MTVEC_WMASK;
                CSR_MSCRATCH: mscratch_d = wdata;
                CSR_MEPC:     mepc_d     = wdata & MEPC_WMASK;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
        end else begin
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
        end
    end

    csr_counter64 u_mcycle (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (1'b1),
        .we_lo_i (we & (csr_addr_i == CSR_MCYCLE)),
        .we_hi_i (we & (csr_addr_i == CSR_MCYCLEH)),
        .wdata_i (wdata),
        .count_o (mcycle)
    );

    // A same-cycle minstret write suppresses the retire increment inside the counter
    csr_counter64 u_minstret (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (retire_i),
        .we_lo_i (we & (csr_addr_i == CSR_MINSTRET)),
        .we_hi_i (we & (csr_addr_i == CSR_MINSTRETH)),
        .wdata_i (wdata),
        .count_o (minstret)
    );

    assign csr_rdata_o = rdata;
    assign illegal_o   = illegal;

endmodule
`default_nettype wire

// File: doc/csr_rw_unit.md
# csr_rw_unit

Machine-mode CSR read/modify/write unit for the RV32I pipeline. It executes CSRRW/CSRRS/CSRRC (register and immediate forms, operand already selected upstream) issued from the EX stage. It owns the writable machine counters (mcycle/minstret) and their user read-only shadows, plus mscratch, mepc and mtvec. It returns the old CSR value to the datapath and flags illegal accesses.

## Interface
- `DATA_WIDTH`, 32, datapath width (global define).
- `CSR_WIDTH`, 64, counter width (global define).
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `csr_valid_i`  in  1  CSR instruction present in EX this cycle.
- `flush_ID_EX_i`  in  1  EX instruction is squashed. The op is suppressed: no write and no illegal flag.
- `csr_op_i`  in  2  operation: 2'd1 = RW, 2'd2 = RS, 2'd3 = RC. The value 2'd0 is treated as no-op.
- `csr_addr_i`  in  12  CSR address.
- `csr_src_i`  in  `DATA_WIDTH`  rs1 value or zero-extended uimm.
- `src_is_x0_i`  in  1  rs1 = x0 (or uimm = 0). RS/RC with this set perform no write.
- `retire_i`  in  1  one instruction retires this cycle.
- `csr_rdata_o`  out  `DATA_WIDTH`  old value of the addressed CSR (combinational).
- `illegal_o`  out  1  illegal CSR access (combinational).

## Operation
- Address map:
  - mtvec 0x305
  - mscratch 0x340
  - mepc 0x341
  - mcycle 0xB00, mcycleh 0xB80
  - minstret 0xB02, minstreth 0xB82
  - cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82. These are read-only aliases of the mcycle/minstret halves.
- Active access: `csr_valid_i & !flush_ID_EX_i & csr_op_i != 0`.
- Write enable = active & !illegal & (op == RW | !src_is_x0_i).
- Next value:
  - RW: src.
  - RS: old | src.
  - RC: old & ~src.
- Field masking on write:
  - mtvec[1:0] forced to 0 (direct mode only).
  - mepc[1:0] forced to 0.
  - All other bits are fully writable.
- `illegal_o` = active & (unmapped address | (address[11:10] == 2'b11 & write would occur per the rule above)).
  - An illegal access changes no state.
  - `csr_rdata_o` returns 0 for unmapped addresses.
- mcycle increments by 1 every cycle.
- minstret increments by 1 when `retire_i` is high.
- A counter write in a cycle overrides that counter's increment for that cycle:
  - The written half takes the new value.
  - The other half holds.
  - No carry is propagated that cycle.
- Increment wraps modulo 2^64. The carry from the low half into the high half is a normal 64-bit add.
- A CSR instruction that writes minstret and also retires the same cycle: the write wins and the retire is not counted.

## Timing
- Read is combinational in the EX cycle and returns the pre-write value (CSR semantics).
- Write commits at the next rising clk edge, so a back-to-back read of the same CSR sees the new value.
- Reset (asynchronous, any time including mid-operation):
  - All registers go to 0; no pending write survives.
  - Outputs settle to the combinational function of the reset state: `illegal_o` = 0 unless an active illegal input is present.
- One write per cycle maximum. No stall or handshake; the unit always accepts.

## Structure
- Shared package `csr_pkg`:
  - CSR address localparams.
  - csr_op enum (NOP/RW/RS/RC).
  - mtvec/mepc write masks.
- Sub-module `csr_counter64`:
  - 64-bit counter with increment enable and per-half write port (we_lo, we_hi, wdata).
  - Instantiated twice, for mcycle and minstret.
- Top level holds the address decode, RMW logic and the scalar registers.

## Test plan
- Reset, then 5 cycles; read mcycle (0xB00) with RS, src_is_x0 = 1 -> rdata = 4 or 5 per sample cycle, no write, illegal = 0. Read cycle (0xC00) -> same value.
- RW mscratch 0x340 with src 0xDEADBEEF -> rdata = 0 that cycle. RS src 0x0000_0010 next cycle -> rdata = 0xDEADBEEF, then holds 0xDEADBEFF. RC src 0xFF -> holds 0xDEADBE00.
- RW mtvec with 0x8000_0003 -> readback 0x8000_0000.
- RW mcycle 0xFFFF_FFFF, then wait 1 cycle -> mcycle = 0x0_0000_0000 and mcycleh incremented by 1.
- RW cycle 0xC00 -> illegal = 1, no change. RS cycle with src_is_x0 = 1 -> illegal = 0.
- RW to unmapped 0x7C0 -> illegal = 1, rdata = 0.
- Valid RW mscratch with flush_ID_EX_i = 1 -> no write, illegal = 0.
- retire_i held high while RW minstret = 100 -> minstret = 100, then 101 the next cycle.
- Assert rst_i mid-sequence -> all registers read 0 immediately after release.
